// File: rtl/usb_line_attach_pkg.sv
// Shared types for the USB line-interface block: pad pair, decoded line state,
// attach FSM states and the polarity-aware line decoder.
package usb_line_attach_pkg;

  // Pad pair as {D-, D+}.
  typedef logic [1:0] d_port_t;

  typedef enum logic [1:0] {
    SE0 = 2'd0,
    J   = 2'd1,
    K   = 2'd2,
    SE1 = 2'd3
  } line_state_t;

  typedef enum logic [1:0] {
    DISC_HOLD = 2'd0,
    DETACHED  = 2'd1,
    ACTIVE    = 2'd2,
    SUSPENDED = 2'd3
  } attach_state_t;

  // Low speed idles with D- high; full speed idles with D+ high.
  function automatic line_state_t decode_line(input d_port_t d, input bit full_speed);
    line_state_t ls;
    case (d)
      2'b00:   ls = SE0;
      2'b11:   ls = SE1;
      2'b10:   ls = full_speed ? K : J;
      default: ls = full_speed ? J : K;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/usb_line_attach_if.sv
// Pad-side and controller-side D+/D- signals owned by the line-attach block.
interface usb_line_attach_if;
  import usb_line_attach_pkg::*;

  d_port_t pad_d_i;
  d_port_t pad_d_o;
  logic    pad_d_oe;
  logic    pullup_en;
  d_port_t ctl_d_o;
  logic    ctl_d_en;
  d_port_t ctl_d_i;

  modport slave (
    input  pad_d_i, ctl_d_o, ctl_d_en,
    output pad_d_o, pad_d_oe, pullup_en, ctl_d_i
  );

  modport master (
    output pad_d_i, ctl_d_o, ctl_d_en,
    input  pad_d_o, pad_d_oe, pullup_en, ctl_d_i
  );

endinterface

// File: rtl/usb_line_sync.sv
// Pad-input synchroniser followed by a registered, polarity-aware line-state decode.
module usb_line_sync
  import usb_line_attach_pkg::*;
#(
  parameter bit FULL_SPEED  = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  d_port_t     pad_d_i,
  output d_port_t     ctl_d_i,
  output line_state_t line_state
);

  d_port_t [SYNC_STAGES-1:0] sync_q, sync_d;
  line_state_t               line_q, line_d;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_d_i};
    line_d = decode_line(sync_q[SYNC_STAGES-1], FULL_SPEED);
  end

  // NOTE: sequential state uses <= so each flop samples pre-edge values; the
  // synchroniser is reset too, so line_state reads SE0 until real pad data arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      line_q <= SE0;
    end else begin
      sync_q <= sync_d;
      line_q <= line_d;
    end
  end

  assign ctl_d_i    = sync_q[SYNC_STAGES-1];
  assign line_state = line_q;

endmodule

// File: rtl/usb_line_attach.sv
// USB device line interface: owns pads and pull-up, sequences attach/detach and
// detects bus reset, suspend and resume from the synchronised line state.
module usb_line_attach
  import usb_line_attach_pkg::*;
#(
  parameter int CLK_HZ      = 24000000,
  parameter bit FULL_SPEED  = 1'b0,
  parameter int SYNC_STAGES = 2,
  parameter int RESET_US    = 2500,
  parameter int SUSPEND_US  = 3000,
  parameter int DISC_US     = 10000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                soft_connect,
  usb_line_attach_if.slave    bus,
  output line_state_t         line_state,
  output logic                attached,
  output logic                bus_reset,
  output logic                suspend,
  output logic                resume_det
);

  localparam int PRESC   = CLK_HZ / 1000000;
  localparam int PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int SE0_W   = $clog2(RESET_US + 1);
  localparam int IDLE_W  = $clog2(SUSPEND_US + 1);
  localparam int DISC_W  = $clog2(DISC_US + 1);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESC - 1);
  localparam logic [SE0_W-1:0]   SE0_MAX   = SE0_W'(RESET_US);
  localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_W'(SUSPEND_US);
  localparam logic [DISC_W-1:0]  DISC_MAX  = DISC_W'(DISC_US);

  attach_state_t       state_q, state_d;
  logic [PRESC_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [SE0_W-1:0]    se0_cnt_q, se0_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [DISC_W-1:0]   disc_cnt_q, disc_cnt_d;
  logic                bus_reset_q, bus_reset_d;
  logic                resume_q, resume_d;

  line_state_t line_st;
  d_port_t     ctl_d_i_w;
  logic        us_tick;
  logic        is_attached;
  logic        se0_hit, idle_hit, disc_done;

  usb_line_sync #(
    .FULL_SPEED  (FULL_SPEED),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .pad_d_i    (bus.pad_d_i),
    .ctl_d_i    (ctl_d_i_w),
    .line_state (line_st)
  );

  assign us_tick     = (pre_cnt_q == PRESC_MAX);
  assign is_attached = (state_q == ACTIVE) || (state_q == SUSPENDED);

  // Line timers only run while attached and never while we drive the bus ourselves.
  always_comb begin
    pre_cnt_d = us_tick ? '0 : pre_cnt_q + 1'b1;

    se0_cnt_d = se0_cnt_q;
    if (!is_attached || bus.ctl_d_en || line_st != SE0)
      se0_cnt_d = '0;
    else if (us_tick && se0_cnt_q != SE0_MAX)
      se0_cnt_d = se0_cnt_q + 1'b1;

    idle_cnt_d = idle_cnt_q;
    if (!is_attached || bus.ctl_d_en || line_st != J || bus_reset_q)
      idle_cnt_d = '0;
    else if (us_tick && idle_cnt_q != IDLE_MAX)
      idle_cnt_d = idle_cnt_q + 1'b1;

    disc_cnt_d = disc_cnt_q;
    if (state_q != DISC_HOLD)
      disc_cnt_d = '0;
    else if (us_tick && disc_cnt_q != DISC_MAX)
      disc_cnt_d = disc_cnt_q + 1'b1;
  end

  assign se0_hit   = (se0_cnt_d == SE0_MAX);
  assign idle_hit  = (idle_cnt_d == IDLE_MAX);
  assign disc_done = (disc_cnt_q == DISC_MAX);

  // Priority when events coincide: detach, then bus reset, then resume, then suspend.
  always_comb begin
    state_d  = state_q;
    resume_d = 1'b0;
    case (state_q)
      DISC_HOLD: if (disc_done) state_d = DETACHED;
      DETACHED:  if (soft_connect) state_d = ACTIVE;
      ACTIVE: begin
        if (!soft_connect)
          state_d = DISC_HOLD;
        else if (!se0_hit && idle_hit)
          state_d = SUSPENDED;
      end
      SUSPENDED: begin
        if (!soft_connect) begin
          state_d = DISC_HOLD;
        end else if (se0_hit) begin
          state_d = ACTIVE;
        end else if (line_st == K) begin
          state_d  = ACTIVE;
          resume_d = 1'b1;
        end
      end
      default: state_d = DISC_HOLD;
    endcase
    bus_reset_d = se0_hit && (state_d == ACTIVE || state_d == SUSPENDED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= DISC_HOLD;
      pre_cnt_q   <= '0;
      se0_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      disc_cnt_q  <= '0;
      bus_reset_q <= 1'b0;
      resume_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      se0_cnt_q   <= se0_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      disc_cnt_q  <= disc_cnt_d;
      bus_reset_q <= bus_reset_d;
      resume_q    <= resume_d;
    end
  end

  assign bus.pad_d_oe  = bus.ctl_d_en && (state_q == ACTIVE);
  assign bus.pad_d_o   = bus.pad_d_oe ? bus.ctl_d_o : '0;
  assign bus.pullup_en = is_attached;
  assign bus.ctl_d_i   = ctl_d_i_w;

  assign line_state = line_st;
  assign attached   = is_attached;
  assign bus_reset  = bus_reset_q;
  assign suspend    = (state_q == SUSPENDED);
  assign resume_det = resume_q;

endmodule
